i2s_receiver: RTL and testbench
===============================

# i2s_receiver

I2S receiver and the receive-side counterpart of the team's I2S master transmitter. It samples an external BCK/LCK/DIN stream, 16-bit two's-complement, MSB first, with a one-BCK delay after each LCK edge. It rebuilds one stereo frame (left + right) per LCK period and presents both words together with a one-cycle VALID strobe. The block runs in the 24 MHz CLK domain as a pure slave: BCK and LCK are inputs and are never generated here.

## Interface
- WIDTH, 16: captured bits per channel word.
- SYNC_STAGES, 2: synchronizer flops on BCK, LCK and DIN (minimum 2).
- CLK  input  1  system clock, 24 MHz; all state on rising edge.
- RST  input  1  reset, asynchronous and active-high.
- BCK  input  1  bit clock, asynchronous to CLK; max frequency CLK/6.
- LCK  input  1  word select, asynchronous; 0 = left, 1 = right; changes on BCK falling edge.
- DIN  input  1  serial data; changes on BCK falling edge.
- SMP_L  output  WIDTH  last complete left sample.
- SMP_R  output  WIDTH  last complete right sample.
- VALID  output  1  one-CLK pulse; SMP_L/SMP_R just updated with a new frame.
- ERR  output  1  one-CLK pulse; a channel word ended with fewer than WIDTH bits.

## Operation
- BCK, LCK and DIN each pass through identical SYNC_STAGES flop chains, so all three stay aligned.
- One extra BCK register detects the rising edge. A BCK rise event (brise) fires for one CLK cycle. All protocol state advances only on brise, using the synchronized LCK/DIN values from the same cycle.
- The LCK value at the previous brise is held in lck_q.
- A word boundary is a brise where LCK differs from lck_q.
- State machine, advancing on brise only:
  - IDLE: entered after reset. Ignores data. On a word boundary, goes to DELAY with chan <= LCK.
  - DELAY: the one-BCK I2S delay slot; the DIN bit is discarded. The next brise goes to SHIFT with bit_cnt=0.
  - SHIFT: shift_reg <= {shift_reg[WIDTH-2:0], DIN}, bit_cnt+1. The brise that captures bit WIDTH-1 completes the word and goes to PAD.
  - PAD: DIN is ignored (trailing zero/padding bits). Stays until a word boundary.
- A word boundary seen in DELAY, SHIFT or PAD restarts: go to DELAY, chan <= LCK. The check is made before any shift on that brise, so the boundary bit is always treated as the delay slot.
- A boundary seen in DELAY or SHIFT means a short word:
  - ERR pulses.
  - The word is discarded.
  - The frame is marked bad.
- Word completion, left channel (chan=0): the word is stored in hold_l and left_ok is set.
- Word completion, right channel (chan=1):
  - If left_ok=1: SMP_L <= hold_l, SMP_R <= word, VALID pulses.
  - left_ok is cleared either way.
  - A right word without a preceding good left word in the same frame gives no VALID and no output change.
- A short left word clears left_ok.
- The first frame after reset is accepted only if its left word began after the IDLE exit.
- bit_cnt is width ceil(log2(WIDTH+1)) and never wraps: PAD absorbs any extra bits, for example 32 BCK per half-frame.

## Timing
- Reset values: SMP_L=0, SMP_R=0, VALID=0, ERR=0. Internally: state IDLE, left_ok=0, lck_q=0, sync chains 0.
- RST mid-frame: immediate return to the reset values. The partial frame is lost. Capture waits for the next LCK boundary.
- brise occurs SYNC_STAGES+1 CLK cycles after a BCK pin rise, ±1 cycle of synchronizer uncertainty.
- VALID and ERR are registered. Each asserts on the CLK cycle after the brise that causes it and lasts exactly one cycle.
- SMP_L/SMP_R change only in the cycle VALID is asserted, never partially. They hold their value otherwise.
- At most one VALID per LCK period. VALID and ERR can never fire together, since they come from different brise events.
- BCK high and low phases must each be ≥3 CLK; slower BCK has no limit.

## Test plan
- Nominal stream (BCK=CLK/8, LCK=BCK/64, 32 BCK per half): send L=0x8001, R=0x7FFE. Required: one VALID with SMP_L=0x8001, SMP_R=0x7FFE. ERR stays 0.
- Back-to-back frames (0x1234/0xABCD, then 0x0000/0xFFFF): exactly two VALIDs, one LCK period apart, each carrying the correct pair.
- Start mid-right-word after reset, then a full frame 0x00FF/0xFF00: the first partial frame gives no VALID. The next full frame gives VALID with 0x00FF/0xFF00.
- LCK toggles after 10 left bits: ERR pulses once. The following right word 0x5555 gives no VALID. The next full frame 0x0F0F/0xF0F0 gives VALID.
- RST asserted mid-SHIFT of the left word 0xCAFE: outputs return to 0 within the same cycle. After release, frame 0x1111/0x2222 gives VALID with those values.
- BCK=CLK/6 with 16 BCK per half (no padding), L=0xA5A5, R=0x5A5A: VALID with the correct values. ERR stays 0.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronizes BCK/LCK/DIN into the CLK domain and rebuilds
// one stereo frame per LCK period, presented with a one-cycle VALID strobe.
module i2s_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BCK,
  input  logic             LCK,
  input  logic             DIN,
  output logic [WIDTH-1:0] SMP_L,
  output logic [WIDTH-1:0] SMP_R,
  output logic             VALID,
  output logic             ERR
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] bck_sync, lck_sync, din_sync;
  logic                   bck_s, lck_s, din_s, bck_d;
  logic                   brise, boundary;
  logic                   lck_q, chan, left_ok;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WIDTH-1:0]       shift_reg, hold_l, word;

  logic start_word, short_word, do_shift, first_bit, word_done;

  // Identical chains keep BCK, LCK and DIN aligned after synchronization.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bck_sync <= '0;
      lck_sync <= '0;
      din_sync <= '0;
      bck_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      bck_sync <= {bck_sync[SYNC_STAGES-2:0], BCK};
      lck_sync <= {lck_sync[SYNC_STAGES-2:0], LCK};
      din_sync <= {din_sync[SYNC_STAGES-2:0], DIN};
      bck_d    <= bck_s;
    end
  end

  assign bck_s    = bck_sync[SYNC_STAGES-1];
  assign lck_s    = lck_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign brise    = bck_s & ~bck_d;
  assign boundary = lck_s ^ lck_q;
  assign word     = {shift_reg[WIDTH-2:0], din_s};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // The boundary brise is always the delay slot; the brise after it carries the MSB.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_nxt  = state;
    start_word = 1'b0;
    short_word = 1'b0;
    do_shift   = 1'b0;
    first_bit  = 1'b0;
    word_done  = 1'b0;
    if (brise) begin
      unique case (state)
        IDLE: begin
          if (boundary) begin
            state_nxt  = DELAY;
            start_word = 1'b1;
          end
        end
        DELAY: begin
          if (boundary) begin
            start_word = 1'b1;
            short_word = 1'b1;
          end else begin
            state_nxt = SHIFT;
            do_shift  = 1'b1;
            first_bit = 1'b1;
          end
        end
        SHIFT: begin
          if (boundary) begin
            state_nxt  = DELAY;
            start_word = 1'b1;
            short_word = 1'b1;
          end else begin
            do_shift = 1'b1;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              word_done = 1'b1;
              state_nxt = PAD;
            end
          end
        end
        PAD: begin
          if (boundary) begin
            state_nxt  = DELAY;
            start_word = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lck_q     <= 1'b0;
      chan      <= 1'b0;
      left_ok   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      hold_l    <= '0;
      SMP_L     <= '0;
      SMP_R     <= '0;
      VALID     <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (brise)      lck_q <= lck_s;
      if (start_word) chan  <= lck_s;
      if (do_shift) begin
        shift_reg <= word;
        bit_cnt   <= first_bit ? CNT_W'(1) : bit_cnt + CNT_W'(1);
      end
      // Any truncated word spoils the frame; a new left word must re-qualify it.
      if (short_word) begin
        ERR     <= 1'b1;
        left_ok <= 1'b0;
      end
      if (word_done) begin
        if (!chan) begin
          hold_l  <= word;
          left_ok <= 1'b1;
        end else begin
          if (left_ok) begin
            SMP_L <= hold_l;
            SMP_R <= word;
            VALID <= 1'b1;
          end
          left_ok <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: half-word level reference model,
// directed frames from the test plan followed by randomized frames.
module tb_i2s_receiver;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST, BCK, LCK, DIN;
  logic [WIDTH-1:0] SMP_L, SMP_R;
  logic             VALID, ERR;

  i2s_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .BCK  (BCK),
    .LCK  (LCK),
    .DIN  (DIN),
    .SMP_L(SMP_L),
    .SMP_R(SMP_R),
    .VALID(VALID),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit               is_err;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
    longint           cyc;
  } ev_t;

  ev_t    dut_q[$];
  ev_t    exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model state, one update per transmitted half-word.
  bit               m_lck_q, m_active, m_prev_short, m_prev_chan, m_left_ok;
  logic [WIDTH-1:0] m_hold;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records strobes and checks outputs only move with VALID.
  logic [WIDTH-1:0] prev_l = '0, prev_r = '0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (VALID) dut_q.push_back('{1'b0, SMP_L, SMP_R, cyc});
      if (ERR)   dut_q.push_back('{1'b1, '0, '0, cyc});
      check("valid_err_exclusive", 32'(VALID & ERR), 32'd0);
      if (!VALID) check("smp_hold", {SMP_L, SMP_R}, {prev_l, prev_r});
    end
    prev_l = SMP_L;
    prev_r = SMP_R;
  end

  task automatic model_reset();
    m_lck_q      = 1'b0;
    m_active     = 1'b0;
    m_prev_short = 1'b0;
    m_prev_chan  = 1'b0;
    m_left_ok    = 1'b0;
    m_hold       = '0;
  endtask

  // A half of n BCKs carries the delay slot plus n-1 data bits; it completes a
  // word only if n-1 >= WIDTH. A short word is reported at the next LCK change.
  task automatic model_half(input bit lck, input int n, input logic [WIDTH-1:0] w);
    if (lck != m_lck_q) begin
      if (m_active && m_prev_short) begin
        exp_q.push_back('{1'b1, '0, '0, 0});
        if (!m_prev_chan) m_left_ok = 1'b0;
      end
      m_active     = 1'b1;
      m_prev_chan  = lck;
      m_prev_short = (n < WIDTH + 1);
      if (!m_prev_short) begin
        if (!lck) begin
          m_hold    = w;
          m_left_ok = 1'b1;
        end else begin
          if (m_left_ok) exp_q.push_back('{1'b0, m_hold, w, 0});
          m_left_ok = 1'b0;
        end
      end
    end
    m_lck_q = lck;
  endtask

  // LCK/DIN change with BCK falling; delay slot and padding bits are random.
  task automatic drive_half(input bit lck, input int n, input logic [WIDTH-1:0] w, input int div);
    int lo = div / 2;
    int hi = div - lo;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      BCK = 1'b0;
      LCK = lck;
      if (k >= 1 && k <= WIDTH) DIN = w[WIDTH-k];
      else                      DIN = 1'($urandom_range(0, 1));
      repeat (lo) @(negedge CLK);
      BCK = 1'b1;
      repeat (hi - 1) @(negedge CLK);
    end
  endtask

  task automatic send_half(input bit lck, input int n, input logic [WIDTH-1:0] w, input int div);
    model_half(lck, n, w);
    drive_half(lck, n, w, div);
  endtask

  task automatic check_events(input string tag, input int period);
    int m;
    repeat (12) @(negedge CLK);
    check({tag, "_count"}, 32'(dut_q.size()), 32'(exp_q.size()));
    m = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_kind%0d", tag, i), 32'(dut_q[i].is_err), 32'(exp_q[i].is_err));
      check($sformatf("%s_l%0d", tag, i), 32'(dut_q[i].l), 32'(exp_q[i].l));
      check($sformatf("%s_r%0d", tag, i), 32'(dut_q[i].r), 32'(exp_q[i].r));
    end
    if (period > 0 && dut_q.size() >= 2) begin
      longint d = dut_q[1].cyc - dut_q[0].cyc;
      check({tag, "_period"}, 32'(d >= longint'(period - 1) && d <= longint'(period + 1)), 32'd1);
    end
    dut_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    BCK = 1'b0;
    LCK = 1'b0;
    DIN = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_smp_l", 32'(SMP_L), 32'd0);
    check("rst_smp_r", 32'(SMP_R), 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_err",   32'(ERR),   32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Capture starts mid right word: that truncated word is short, no VALID for it.
    send_half(1'b1, 8,  16'h1234, 8);
    send_half(1'b0, 32, 16'h00FF, 8);
    send_half(1'b1, 32, 16'hFF00, 8);
    check_events("midstart", 0);

    send_half(1'b0, 32, 16'h8001, 8);
    send_half(1'b1, 32, 16'h7FFE, 8);
    check_events("nominal", 0);

    send_half(1'b0, 32, 16'h1234, 8);
    send_half(1'b1, 32, 16'hABCD, 8);
    send_half(1'b0, 32, 16'h0000, 8);
    send_half(1'b1, 32, 16'hFFFF, 8);
    check_events("b2b", 64 * 8);

    // Left word cut after 10 data bits.
    send_half(1'b0, 11, 16'h1357, 8);
    send_half(1'b1, 32, 16'h5555, 8);
    send_half(1'b0, 32, 16'h0F0F, 8);
    send_half(1'b1, 32, 16'hF0F0, 8);
    check_events("short", 0);

    // Reset while shifting the left word 0xCAFE; the outputs hold 0x0F0F/0xF0F0 before it.
    drive_half(1'b0, 9, 16'hCAFE, 8);
    RST = 1'b1;
    BCK = 1'b0;
    #1;
    check("midrst_smp_l", 32'(SMP_L), 32'd0);
    check("midrst_smp_r", 32'(SMP_R), 32'd0);
    check("midrst_valid", 32'(VALID), 32'd0);
    check("midrst_err",   32'(ERR),   32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (4) @(negedge CLK);
    send_half(1'b1, 32, 16'($urandom), 8);
    send_half(1'b0, 32, 16'h1111, 8);
    send_half(1'b1, 32, 16'h2222, 8);
    check_events("after_rst", 0);

    // Fastest BCK and shortest complete half: delay slot plus WIDTH bits.
    send_half(1'b0, WIDTH + 1, 16'hA5A5, 6);
    send_half(1'b1, WIDTH + 1, 16'h5A5A, 6);
    check_events("fast", 0);

    for (int f = 0; f < 12; f++) begin
      int div = $urandom_range(6, 10);
      for (int ch = 0; ch < 2; ch++) begin
        int n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH) : $urandom_range(WIDTH + 1, 32);
        send_half(ch[0], n, 16'($urandom), div);
      end
    end
    check_events("random", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
